mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage plus MEM/WB pipeline register, directly downstream of the EXE/MEM register. It consumes the `mem_*` bundle and runs loads and stores over a req/ack data-memory port with a bounded-wait timeout. While an access is outstanding it stalls the upstream pipeline. It selects the write-back value from load data, MOV data or ALU result, and registers the result for the WB stage.

## Interface
- `TIMEOUT`, 16: maximum cycles in WAIT without `dm_ack` before the access is aborted. Legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset (`RstEnable`).
- `mem_sw_o` in `RegBus` (32): store data.
- `mem_write_o` in 32: MOV data.
- `mem_alu_result` in 32: ALU result, also the DM byte address.
- `mem_lwsrc` in 1: `LwAluSrc`=0 or `LwMemSrc`=1.
- `mem_movsrc` in 1: `MvAluSrc`=0 or `MvMovSrc`=1.
- `mem_write_addr_o` in `RegAddrBus` (5): destination register.
- `mem_reg_write`, `mem_DM_read`, `mem_DM_write` in 1 each.
- `stall_o` out 1: hold EXE/MEM and all earlier stages.
- `dm_req`, `dm_we` out 1 each.
- `dm_addr`, `dm_wdata` out 32.
- `dm_ack` in 1.
- `dm_rdata` in 32.
- `dm_err` out 1: one-cycle pulse on timeout or illegal op.
- `wb_write_addr_o` out 5.
- `wb_reg_write` out 1.
- `wb_data` out 32.

## Operation
- FSM states are IDLE, WAIT and DONE. The reset state is IDLE.
- IDLE, op has `mem_DM_read`=1 or `mem_DM_write`=1:
  - `stall_o`=1 combinationally.
  - Next state is WAIT.
  - `dm_req`, `dm_we` (=`mem_DM_write`), `dm_addr` (=`mem_alu_result`) and `dm_wdata` (=`mem_sw_o`) register at the same edge.
- IDLE, no memory op: `stall_o`=0 and the op passes straight into the WB register.
- WAIT:
  - `stall_o`=1 and `dm_req` is held with all request fields stable.
  - The wait counter increments each cycle.
  - `dm_ack` sampled 1: capture `dm_rdata`, drop `dm_req`, go to DONE.
  - Counter reaches `TIMEOUT`: drop `dm_req`, pulse `dm_err`, set the abort flag, go to DONE.
- DONE:
  - `stall_o`=0.
  - The WB register loads the op, then the FSM returns to IDLE.
  - An aborted load forces `wb_reg_write`=0.
- Write-back select, in priority order:
  - `mem_lwsrc`=`LwMemSrc` gives the captured load data.
  - Else `mem_movsrc`=`MvMovSrc` gives `mem_write_o`.
  - Else `mem_alu_result`.
- While `stall_o`=1 the WB register loads a bubble: `wb_reg_write`=0, with addr and data unchanged. This prevents a double register-file write.
- `mem_DM_read` and `mem_DM_write` both 1 is illegal:
  - It is treated as a store.
  - `dm_err` pulses in the IDLE cycle that launches it.
- `dm_ack` in IDLE or DONE is ignored.
- The counter clears on every entry to WAIT.

## Timing
- Reset values:
  - `dm_req`=0, `dm_we`=0, `dm_err`=0.
  - `dm_addr`=`ZeroWord`, `dm_wdata`=`ZeroWord`.
  - `wb_reg_write`=`WriteDisable`.
  - `wb_write_addr_o`=`ZeroRegAddr`, `wb_data`=`ZeroWord`.
  - `stall_o`=0, state IDLE, counter 0.
- Reset mid-access: `dm_req` drops immediately (asynchronous), and any later ack is ignored.
- Non-memory op: WB outputs are valid 1 cycle after the op is presented.
- Load or store with ack in the first WAIT cycle:
  - Cycle 0: IDLE with the op presented.
  - Cycle 1: WAIT with `dm_req`=1 and ack=1.
  - Cycle 2: DONE with `stall_o`=0.
  - WB outputs are valid in cycle 3.
  - The stall lasts 2 cycles.
- Ack after k WAIT cycles: the stall lasts k+1 cycles.
- Timeout: the stall lasts `TIMEOUT`+1 cycles, and `dm_err` is high in the cycle the FSM enters DONE.
- Back-to-back memory ops: the next op is accepted in IDLE the cycle after DONE.

## Structure
- `port_define.sv` holds `LwMemSrc`, `MvMovSrc` and `DmTimeoutDefault`.
- A shared pipeline package holds the state enum `mem_state_t` (IDLE/WAIT/DONE).
- One sub-module, `mem_dm_ctrl`, contains the FSM, wait counter, request registers and abort flag.
- The write-back mux and WB register live in `mem_stage`.

## Test plan
- Reset, then ALU op with `mem_alu_result`=0x00000010, addr 3, reg_write=1 -> next cycle `wb_data`=0x10, `wb_write_addr_o`=3, `wb_reg_write`=1, `stall_o` never 1.
- Load, addr 0x100, `dm_ack` after 3 WAIT cycles with `dm_rdata`=0xDEADBEEF -> `stall_o` high 4 cycles, `dm_req` stable, then `wb_data`=0xDEADBEEF, one `wb_reg_write` pulse.
- Store, addr 0x40, `mem_sw_o`=0x12345678, immediate ack -> `dm_we`=1, `dm_wdata`=0x12345678, 2-cycle stall, `wb_reg_write`=0.
- Load with ack held low, `TIMEOUT`=4 -> `dm_err` single pulse, `dm_req` drops, `wb_reg_write`=0, `stall_o` released after 5 cycles.
- Reset asserted during WAIT, then ack arrives -> `dm_req`=0 immediately, state IDLE, ack ignored, all outputs at reset values.
- MOV op with `mem_movsrc`=1, `mem_write_o`=0xA5 -> `wb_data`=0xA5. Read and write both 1 -> store issued, `dm_err` pulse.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Pipeline types shared by the memory stage and its data-memory controller.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } mem_state_t;

endpackage

// File: rtl/port_define.sv
// Shared encodings for the pipeline datapath: bus widths, reset constants and mux selects.
package port_define;

   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;

   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic [RegAddrBus-1:0] ZeroRegAddr  = '0;
   localparam logic                  WriteDisable = 1'b0;

   localparam logic LwAluSrc = 1'b0;
   localparam logic LwMemSrc = 1'b1;
   localparam logic MvAluSrc = 1'b0;
   localparam logic MvMovSrc = 1'b1;

   localparam int DmTimeoutDefault = 16;

endpackage

// File: rtl/mem_dm_ctrl.sv
// Data-memory access controller: request launch, bounded wait for ack, abort on timeout.
module mem_dm_ctrl
   import port_define::*;
   import mem_stage_pkg::*;
#(
   parameter int TIMEOUT = DmTimeoutDefault
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [RegBus-1:0] i_addr,
   input  logic [RegBus-1:0] i_wdata,
   input  logic              i_ack,
   input  logic [RegBus-1:0] i_rdata,
   output logic              o_req,
   output logic              o_we,
   output logic [RegBus-1:0] o_addr,
   output logic [RegBus-1:0] o_wdata,
   output logic              o_err,
   output logic              o_stall,
   output logic              o_done,
   output logic              o_abort,
   output logic [RegBus-1:0] o_loadData
);

   localparam logic [7:0] TimeoutCount = 8'(TIMEOUT);

   mem_state_t        r_state;
   mem_state_t        w_nextState;
   logic [7:0]        r_waitCount;
   logic              r_errPulse;
   logic              r_abort;
   logic [RegBus-1:0] r_loadData;
   logic              w_memOp;
   logic              w_launch;
   logic              w_ackHit;
   logic              w_timeout;

   assign w_memOp = i_read | i_write;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Ack wins over a timeout landing in the same WAIT cycle.
   always_comb begin
      w_nextState = r_state;
      w_launch    = 1'b0;
      w_ackHit    = 1'b0;
      w_timeout   = 1'b0;
      o_stall     = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_memOp) begin
               o_stall     = 1'b1;
               w_launch    = 1'b1;
               w_nextState = WAIT;
            end
         end
         WAIT: begin
            o_stall = 1'b1;
            if (i_ack) begin
               w_ackHit    = 1'b1;
               w_nextState = DONE;
            end else if (r_waitCount + 8'd1 == TimeoutCount) begin
               w_timeout   = 1'b1;
               w_nextState = DONE;
            end
         end
         DONE: begin
            w_nextState = IDLE;
         end
         default: begin
            w_nextState = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_waitCount <= 8'd0;
      end else if (w_launch) begin
         r_waitCount <= 8'd0;
      end else if (r_state == WAIT) begin
         r_waitCount <= r_waitCount + 8'd1;
      end
   end

   // Request fields are frozen from launch until ack or abort.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o_req   <= 1'b0;
         o_we    <= 1'b0;
         o_addr  <= ZeroWord;
         o_wdata <= ZeroWord;
      end else if (w_launch) begin
         o_req   <= 1'b1;
         o_we    <= i_write;
         o_addr  <= i_addr;
         o_wdata <= i_wdata;
      end else if (w_ackHit || w_timeout) begin
         o_req   <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_loadData <= ZeroWord;
         r_errPulse <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_errPulse <= w_timeout;
         if (w_ackHit) begin
            r_loadData <= i_rdata;
         end
         if (w_launch) begin
            r_abort <= 1'b0;
         end else if (w_timeout) begin
            r_abort <= 1'b1;
         end
      end
   end

   assign o_err      = r_errPulse | (w_launch & i_read & i_write);
   assign o_done     = (r_state == DONE);
   assign o_abort    = r_abort;
   assign o_loadData = r_loadData;

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage with MEM/WB pipeline register; stalls upstream while a DM access is open.
module mem_stage
   import port_define::*;
#(
   parameter int TIMEOUT = DmTimeoutDefault
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [RegBus-1:0]     mem_sw_o,
   input  logic [RegBus-1:0]     mem_write_o,
   input  logic [RegBus-1:0]     mem_alu_result,
   input  logic                  mem_lwsrc,
   input  logic                  mem_movsrc,
   input  logic [RegAddrBus-1:0] mem_write_addr_o,
   input  logic                  mem_reg_write,
   input  logic                  mem_DM_read,
   input  logic                  mem_DM_write,
   output logic                  stall_o,
   output logic                  dm_req,
   output logic                  dm_we,
   output logic [RegBus-1:0]     dm_addr,
   output logic [RegBus-1:0]     dm_wdata,
   input  logic                  dm_ack,
   input  logic [RegBus-1:0]     dm_rdata,
   output logic                  dm_err,
   output logic [RegAddrBus-1:0] wb_write_addr_o,
   output logic                  wb_reg_write,
   output logic [RegBus-1:0]     wb_data
);

   logic              w_stall;
   logic              w_done;
   logic              w_abort;
   logic              w_isLoad;
   logic [RegBus-1:0] w_loadData;
   logic [RegBus-1:0] w_wbData;

   mem_dm_ctrl #(
      .TIMEOUT (TIMEOUT)
   ) u_dmCtrl (
      .clk        (clk),
      .rst        (rst),
      .i_read     (mem_DM_read),
      .i_write    (mem_DM_write),
      .i_addr     (mem_alu_result),
      .i_wdata    (mem_sw_o),
      .i_ack      (dm_ack),
      .i_rdata    (dm_rdata),
      .o_req      (dm_req),
      .o_we       (dm_we),
      .o_addr     (dm_addr),
      .o_wdata    (dm_wdata),
      .o_err      (dm_err),
      .o_stall    (w_stall),
      .o_done     (w_done),
      .o_abort    (w_abort),
      .o_loadData (w_loadData)
   );

   assign stall_o  = w_stall;
   assign w_isLoad = mem_DM_read & ~mem_DM_write;

   always_comb begin
      w_wbData = mem_alu_result;
      if (mem_lwsrc == LwMemSrc) begin
         w_wbData = w_loadData;
      end else if (mem_movsrc == MvMovSrc) begin
         w_wbData = mem_write_o;
      end
   end

   // A stalled cycle inserts a bubble so the held op is written back exactly once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_reg_write    <= WriteDisable;
         wb_write_addr_o <= ZeroRegAddr;
         wb_data         <= ZeroWord;
      end else if (w_stall) begin
         wb_reg_write    <= WriteDisable;
      end else begin
         wb_reg_write    <= mem_reg_write & ~(w_done & w_abort & w_isLoad);
         wb_write_addr_o <= mem_write_addr_o;
         wb_data         <= w_wbData;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: vector table for pass-through ops plus hand sequences for DM accesses.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] mem_sw_o = '0;
   logic [31:0] mem_write_o = '0;
   logic [31:0] mem_alu_result = '0;
   logic        mem_lwsrc = 1'b0;
   logic        mem_movsrc = 1'b0;
   logic [4:0]  mem_write_addr_o = '0;
   logic        mem_reg_write = 1'b0;
   logic        mem_DM_read = 1'b0;
   logic        mem_DM_write = 1'b0;
   logic        stall_o;
   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_ack = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic        dm_err;
   logic [4:0]  wb_write_addr_o;
   logic        wb_reg_write;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage #(
      .TIMEOUT (4)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .mem_sw_o         (mem_sw_o),
      .mem_write_o      (mem_write_o),
      .mem_alu_result   (mem_alu_result),
      .mem_lwsrc        (mem_lwsrc),
      .mem_movsrc       (mem_movsrc),
      .mem_write_addr_o (mem_write_addr_o),
      .mem_reg_write    (mem_reg_write),
      .mem_DM_read      (mem_DM_read),
      .mem_DM_write     (mem_DM_write),
      .stall_o          (stall_o),
      .dm_req           (dm_req),
      .dm_we            (dm_we),
      .dm_addr          (dm_addr),
      .dm_wdata         (dm_wdata),
      .dm_ack           (dm_ack),
      .dm_rdata         (dm_rdata),
      .dm_err           (dm_err),
      .wb_write_addr_o  (wb_write_addr_o),
      .wb_reg_write     (wb_reg_write),
      .wb_data          (wb_data)
   );

   typedef struct {
      logic        movsrc;
      logic [31:0] alu;
      logic [31:0] mov;
      logic [4:0]  dst;
      logic        regW;
      logic [31:0] expData;
      logic [4:0]  expAddr;
      logic        expRegW;
   } vec_t;

   vec_t vecs[4];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic lwsrc, input logic movsrc,
                                input logic regW, input logic [4:0] dst, input logic [31:0] alu,
                                input logic [31:0] sw, input logic [31:0] mov);
      mem_DM_read      = rd;
      mem_DM_write     = wr;
      mem_lwsrc        = lwsrc;
      mem_movsrc       = movsrc;
      mem_reg_write    = regW;
      mem_write_addr_o = dst;
      mem_alu_result   = alu;
      mem_sw_o         = sw;
      mem_write_o      = mov;
   endtask

   // Called at posedge+1 with the op already applied; returns mid-cycle in the first unstalled cycle.
   task automatic runAccess(input int ackAt, input logic [31:0] rdata, input logic expWe,
                            input logic [31:0] expAddr, input logic [31:0] expWdata,
                            output int stallCycles, output int errStall, output int errDone,
                            output int reqBad);
      int waitIdx;
      int budget;
      waitIdx     = 0;
      budget      = 0;
      stallCycles = 0;
      errStall    = 0;
      errDone     = 0;
      reqBad      = 0;
      #2;
      while (stall_o === 1'b1 && budget < 300) begin
         stallCycles++;
         if (dm_err === 1'b1) errStall++;
         if (dm_req === 1'b1) begin
            waitIdx++;
            if (dm_we !== expWe || dm_addr !== expAddr || dm_wdata !== expWdata) reqBad++;
         end
         dm_rdata = rdata;
         dm_ack   = (dm_req === 1'b1 && waitIdx == ackAt);
         @(posedge clk);
         #1;
         dm_ack = 1'b0;
         #2;
         budget++;
      end
      checkOutput("access finished within budget", (budget < 300), 1'b1);
      if (dm_err === 1'b1) errDone++;
   endtask

   // Steps past the DONE edge, returns the op to a NOP, leaves WB holding the accessed op.
   task automatic finishAccess();
      @(posedge clk);
      #1;
      applyStimulus(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      #2;
   endtask

   initial begin : watchdog
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : main
      int stallCycles, errStall, errDone, reqBad;

      vecs[0] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 5'd3,  1'b1, 32'h0000_0010, 5'd3,  1'b1};
      vecs[1] = '{1'b1, 32'h0000_0077, 32'h0000_00A5, 5'd7,  1'b1, 32'h0000_00A5, 5'd7,  1'b1};
      vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0055, 5'd31, 1'b0, 32'hFFFF_FFFF, 5'd31, 1'b0};
      vecs[3] = '{1'b0, 32'h0000_1234, 32'h0000_0055, 5'd1,  1'b1, 32'h0000_1234, 5'd1,  1'b1};

      #3;
      checkOutput("reset dm_req", dm_req, 1'b0);
      checkOutput("reset dm_we", dm_we, 1'b0);
      checkOutput("reset dm_err", dm_err, 1'b0);
      checkOutput("reset dm_addr", dm_addr, 32'h0);
      checkOutput("reset dm_wdata", dm_wdata, 32'h0);
      checkOutput("reset stall_o", stall_o, 1'b0);
      checkOutput("reset wb_reg_write", wb_reg_write, 1'b0);
      checkOutput("reset wb_write_addr_o", wb_write_addr_o, 5'd0);
      checkOutput("reset wb_data", wb_data, 32'h0);
      #9;
      rst = 1'b0;

      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         applyStimulus(0, 0, 0, vecs[i].movsrc, vecs[i].regW, vecs[i].dst, vecs[i].alu, 32'h0, vecs[i].mov);
         #2;
         checkOutput($sformatf("vec%0d stall_o", i), stall_o, 1'b0);
         @(posedge clk);
         #1;
         applyStimulus(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
         #2;
         checkOutput($sformatf("vec%0d wb_data", i), wb_data, vecs[i].expData);
         checkOutput($sformatf("vec%0d wb_write_addr_o", i), wb_write_addr_o, vecs[i].expAddr);
         checkOutput($sformatf("vec%0d wb_reg_write", i), wb_reg_write, vecs[i].expRegW);
      end

      // Load, ack in the third WAIT cycle; movsrc also set to confirm load data has priority.
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 1, 1, 1, 5'd5, 32'h0000_0100, 32'h0, 32'h0000_0011);
      runAccess(3, 32'hDEAD_BEEF, 1'b0, 32'h0000_0100, 32'h0, stallCycles, errStall, errDone, reqBad);
      checkOutput("load stall cycles", stallCycles, 4);
      checkOutput("load req stable", reqBad, 0);
      checkOutput("load dm_req in DONE", dm_req, 1'b0);
      checkOutput("load no dm_err", errStall + errDone, 0);
      checkOutput("load wb bubble in DONE", wb_reg_write, 1'b0);
      finishAccess();
      checkOutput("load wb_data", wb_data, 32'hDEAD_BEEF);
      checkOutput("load wb_write_addr_o", wb_write_addr_o, 5'd5);
      checkOutput("load wb_reg_write", wb_reg_write, 1'b1);
      @(posedge clk);
      #3;
      checkOutput("load single wb pulse", wb_reg_write, 1'b0);

      // Store with immediate ack.
      @(posedge clk);
      #1;
      applyStimulus(0, 1, 0, 0, 0, 5'd0, 32'h0000_0040, 32'h1234_5678, 32'h0);
      runAccess(1, 32'h0, 1'b1, 32'h0000_0040, 32'h1234_5678, stallCycles, errStall, errDone, reqBad);
      checkOutput("store stall cycles", stallCycles, 2);
      checkOutput("store req fields", reqBad, 0);
      checkOutput("store no dm_err", errStall + errDone, 0);
      finishAccess();
      checkOutput("store wb_reg_write", wb_reg_write, 1'b0);

      // Load that never sees ack: TIMEOUT is 4.
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 1, 0, 1, 5'd9, 32'h0000_0200, 32'h0, 32'h0);
      runAccess(0, 32'h0, 1'b0, 32'h0000_0200, 32'h0, stallCycles, errStall, errDone, reqBad);
      checkOutput("timeout stall cycles", stallCycles, 5);
      checkOutput("timeout err before DONE", errStall, 0);
      checkOutput("timeout err in DONE", errDone, 1);
      checkOutput("timeout dm_req dropped", dm_req, 1'b0);
      finishAccess();
      checkOutput("timeout dm_err single pulse", dm_err, 1'b0);
      checkOutput("timeout wb_reg_write", wb_reg_write, 1'b0);

      // Read and write together: issued as a store, error flagged in the launch cycle.
      @(posedge clk);
      #1;
      applyStimulus(1, 1, 0, 0, 0, 5'd2, 32'h0000_0080, 32'hCAFE_F00D, 32'h0);
      runAccess(1, 32'h0, 1'b1, 32'h0000_0080, 32'hCAFE_F00D, stallCycles, errStall, errDone, reqBad);
      checkOutput("illegal stall cycles", stallCycles, 2);
      checkOutput("illegal issued as store", reqBad, 0);
      checkOutput("illegal dm_err pulses", errStall + errDone, 1);
      finishAccess();

      // Reset in the middle of WAIT, then a late ack.
      @(posedge clk);
      #1;
      applyStimulus(1, 0, 1, 0, 1, 5'd4, 32'h0000_0300, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #3;
      checkOutput("pre-reset dm_req", dm_req, 1'b1);
      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h0);
      dm_ack = 1'b1;
      #1;
      checkOutput("async reset dm_req", dm_req, 1'b0);
      checkOutput("async reset stall_o", stall_o, 1'b0);
      checkOutput("async reset wb_data", wb_data, 32'h0);
      checkOutput("async reset dm_addr", dm_addr, 32'h0);
      #3;
      rst = 1'b0;
      @(posedge clk);
      #3;
      checkOutput("ack after reset dm_req", dm_req, 1'b0);
      checkOutput("ack after reset dm_err", dm_err, 1'b0);
      checkOutput("ack after reset stall_o", stall_o, 1'b0);
      checkOutput("ack after reset wb_reg_write", wb_reg_write, 1'b0);
      checkOutput("ack after reset wb_write_addr_o", wb_write_addr_o, 5'd0);
      dm_ack = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
